// File: rtl/bus_xbar_fsm_if.sv
// CPU-side access port of the bus crossbar: valid/ready request with a
// one-cycle rvalid response carrying rdata/error.
interface bus_xbar_fsm_if #(
  parameter int XLEN = 32
);
  logic              acs_valid;
  logic              acs_ready;
  logic              acs_wr;
  logic [XLEN/8-1:0] acs_bytes;
  logic [XLEN-1:0]   acs_addr;
  logic [XLEN-1:0]   acs_wdata;
  logic              acs_rvalid;
  logic [XLEN-1:0]   acs_rdata;
  logic              acs_error;

  // The CPU / load-store unit side issues requests.
  modport master (
    output acs_valid, acs_wr, acs_bytes, acs_addr, acs_wdata,
    input  acs_ready, acs_rvalid, acs_rdata, acs_error
  );

  // The crossbar accepts requests and returns responses.
  modport slave (
    input  acs_valid, acs_wr, acs_bytes, acs_addr, acs_wdata,
    output acs_ready, acs_rvalid, acs_rdata, acs_error
  );
endinterface

// File: rtl/bus_xbar_fsm.sv
// Registered address-decode crossbar. One CPU access in flight at a time:
// the address MSBs select one of NSLV slave ports, the select is held until
// that slave answers (or the access times out), and the result is returned
// to the CPU as a single rvalid pulse. Unmapped addresses answer with error.
module bus_xbar_fsm #(
  parameter int                    XLEN     = 32,
  parameter int                    NSLV     = 4,
  parameter int                    SEL_W    = 5,
  parameter logic [NSLV*SEL_W-1:0] SLV_BASE = {5'b10110, 5'b10100, 5'b10000, 5'b00000},
  parameter logic [NSLV-1:0]       SLV_EN   = 4'b0111,
  parameter int                    TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_xbar_fsm_if.slave        acs,
  output logic [NSLV-1:0]      s_cen,
  output logic                 s_wr,
  output logic [XLEN/8-1:0]    s_strb,
  output logic [31-SEL_W:0]    s_addr,
  output logic [XLEN-1:0]      s_wdata,
  input  logic [NSLV*XLEN-1:0] s_rdata,
  input  logic [NSLV-1:0]      s_rvalid,
  input  logic [NSLV-1:0]      s_error
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so a
  // disabled timeout still elaborates cleanly.
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rvalid_q;
  logic [XLEN-1:0]  rdata_q;
  logic             error_q;

  logic [NSLV-1:0]  hit_oh;
  logic             hit;
  logic             hi_ok;
  logic             sel_rvalid;
  logic             sel_error;
  logic [XLEN-1:0]  sel_rdata;

  assign acs.acs_ready  = (state == IDLE);
  assign acs.acs_rvalid = rvalid_q;
  assign acs.acs_rdata  = rdata_q;
  assign acs.acs_error  = error_q;

  // On RV64 the upper address word must be a sign extension of the low
  // word (all zeros or all ones); anything else is outside the bus map.
  if (XLEN > 32) begin : g_hi_chk
    logic [XLEN-33:0] addr_hi;
    assign addr_hi = acs.acs_addr[XLEN-1:32];
    assign hi_ok   = (addr_hi == '0) || (addr_hi == '1);
  end else begin : g_no_hi_chk
    assign hi_ok = 1'b1;
  end

  // Address decode: first enabled slot whose base matches the MSBs wins.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    hit_oh = '0;
    hit    = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (!hit && SLV_EN[k] &&
          (acs.acs_addr[31 -: SEL_W] == SLV_BASE[k*SEL_W +: SEL_W])) begin
        hit_oh[k] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  // Response mux: only the currently selected slot is visible, so strobes
  // on other slots are masked out by the one-hot select.
  always_comb begin
    sel_rvalid = |(s_rvalid & s_cen);
    sel_error  = |(s_error & s_cen);
    sel_rdata  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (s_cen[k]) begin
        sel_rdata = sel_rdata | s_rdata[k*XLEN +: XLEN];
      end
    end
  end

  // Access FSM with registered slave-side and CPU-response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      s_cen    <= '0;
      s_wr     <= 1'b0;
      s_strb   <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees
      // the pre-edge value of every other; this default is overridden below.
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acs.acs_valid) begin
            s_wr    <= acs.acs_wr;
            s_strb  <= acs.acs_bytes;
            s_addr  <= acs.acs_addr[31-SEL_W:0];
            s_wdata <= acs.acs_wdata;
            cnt     <= '0;
            if (hit && hi_ok) begin
              s_cen <= hit_oh;
              state <= BUSY;
            end else begin
              state <= ERR;
            end
          end
        end

        BUSY: begin
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          // A completion in the threshold cycle takes priority over timeout.
          if (sel_rvalid) begin
            rdata_q  <= s_wr ? '0 : sel_rdata;
            error_q  <= sel_error;
            s_cen    <= '0;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            rdata_q  <= '0;
            error_q  <= 1'b1;
            s_cen    <= '0;
            rvalid_q <= 1'b1;
            state    <= RESP;
          end
        end

        ERR: begin
          rdata_q  <= '0;
          error_q  <= 1'b1;
          rvalid_q <= 1'b1;
          state    <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xbar_fsm.sv
// Directed bench for bus_xbar_fsm: an RV32 instance (TIMEOUT=8) covers
// reads, writes, wait states, decode miss, slave error, timeout and reset
// mid-access; an RV64 instance covers the upper-address-word check.
module tb_bus_xbar_fsm;

  localparam logic [19:0] BASES = {5'b00010, 5'b10110, 5'b10100, 5'b10000};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RV32 instance
  bus_xbar_fsm_if #(.XLEN(32)) acs ();
  logic [3:0]   s_cen;
  logic         s_wr;
  logic [3:0]   s_strb;
  logic [26:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_rvalid;
  logic [3:0]   s_error;

  bus_xbar_fsm #(
    .XLEN(32), .NSLV(4), .SEL_W(5), .SLV_BASE(BASES),
    .SLV_EN(4'b0111), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .acs(acs),
    .s_cen(s_cen), .s_wr(s_wr), .s_strb(s_strb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_error(s_error)
  );

  // RV64 instance
  bus_xbar_fsm_if #(.XLEN(64)) acs64 ();
  logic [3:0]   s64_cen;
  logic         s64_wr;
  logic [7:0]   s64_strb;
  logic [26:0]  s64_addr;
  logic [63:0]  s64_wdata;
  logic [255:0] s64_rdata;
  logic [3:0]   s64_rvalid;
  logic [3:0]   s64_error;

  bus_xbar_fsm #(
    .XLEN(64), .NSLV(4), .SEL_W(5), .SLV_BASE(BASES),
    .SLV_EN(4'b0111), .TIMEOUT(255)
  ) dut64 (
    .clk(clk), .rst_n(rst_n), .acs(acs64),
    .s_cen(s64_cen), .s_wr(s64_wr), .s_strb(s64_strb), .s_addr(s64_addr),
    .s_wdata(s64_wdata), .s_rdata(s64_rdata), .s_rvalid(s64_rvalid),
    .s_error(s64_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    acs.acs_valid   = 1'b0;
    acs.acs_wr      = 1'b0;
    acs.acs_bytes   = '0;
    acs.acs_addr    = '0;
    acs.acs_wdata   = '0;
    s_rdata         = '0;
    s_rvalid        = '0;
    s_error         = '0;
    acs64.acs_valid = 1'b0;
    acs64.acs_wr    = 1'b0;
    acs64.acs_bytes = '0;
    acs64.acs_addr  = '0;
    acs64.acs_wdata = '0;
    s64_rdata       = '0;
    s64_rvalid      = '0;
    s64_error       = '0;

    // ---- reset values ----
    tick();
    tick();
    check("rst_ready",  acs.acs_ready, 1);
    check("rst_rvalid", acs.acs_rvalid, 0);
    check("rst_error",  acs.acs_error, 0);
    check("rst_rdata",  acs.acs_rdata, 0);
    check("rst_cen",    s_cen, 0);
    check("rst_wr",     s_wr, 0);
    check("rst_strb",   s_strb, 0);
    check("rst_addr",   s_addr, 0);
    check("rst_wdata",  s_wdata, 0);
    rst_n = 1'b1;
    tick();

    // ---- zero-wait read of slot 0 ----
    acs.acs_valid = 1'b1; acs.acs_wr = 1'b0; acs.acs_bytes = 4'hF;
    acs.acs_addr  = 32'h8000_0010;
    check("rd0_c0_ready", acs.acs_ready, 1);
    tick();                                         // cycle 1
    acs.acs_valid = 1'b0;
    check("rd0_c1_cen",   s_cen, 4'b0001);
    check("rd0_c1_ready", acs.acs_ready, 0);
    check("rd0_c1_addr",  s_addr, 27'h10);
    check("rd0_c1_rv",    acs.acs_rvalid, 0);
    s_rdata[31:0] = 32'hDEAD_BEEF; s_rvalid = 4'b0001;
    tick();                                         // cycle 2
    s_rvalid = '0;
    check("rd0_c2_rv",    acs.acs_rvalid, 1);
    check("rd0_c2_rdata", acs.acs_rdata, 32'hDEAD_BEEF);
    check("rd0_c2_err",   acs.acs_error, 0);
    check("rd0_c2_cen",   s_cen, 0);
    tick();                                         // cycle 3
    check("rd0_c3_ready", acs.acs_ready, 1);
    check("rd0_c3_rv",    acs.acs_rvalid, 0);

    // ---- write slot 1 with 5 wait cycles ----
    acs.acs_valid = 1'b1; acs.acs_wr = 1'b1; acs.acs_bytes = 4'b0001;
    acs.acs_addr  = 32'hA000_0000; acs.acs_wdata = 32'h41;
    s_rdata[63:32] = 32'hFFFF_FFFF;                 // must not leak on a write
    tick();                                         // cycle 1
    acs.acs_valid = 1'b0; acs.acs_wr = 1'b0;
    check("wr_c1_cen",   s_cen, 4'b0010);
    check("wr_c1_wdata", s_wdata, 32'h41);
    check("wr_c1_strb",  s_strb, 4'b0001);
    check("wr_c1_wr",    s_wr, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      check($sformatf("wr_c%0d_cen", c), s_cen, 4'b0010);
      check($sformatf("wr_c%0d_rv", c), acs.acs_rvalid, 0);
    end
    s_rvalid = 4'b0010;                             // completion in cycle 6
    tick();                                         // cycle 7
    s_rvalid = '0;
    check("wr_c7_rv",    acs.acs_rvalid, 1);
    check("wr_c7_err",   acs.acs_error, 0);
    check("wr_c7_rdata", acs.acs_rdata, 0);
    check("wr_c7_cen",   s_cen, 0);
    tick();
    check("wr_c8_ready", acs.acs_ready, 1);

    // ---- decode miss: would hit slot 3, which is disabled ----
    acs.acs_valid = 1'b1; acs.acs_addr = 32'h1000_0000;
    tick();                                         // cycle 1
    acs.acs_valid = 1'b0;
    check("miss_c1_cen", s_cen, 0);
    check("miss_c1_rv",  acs.acs_rvalid, 0);
    tick();                                         // cycle 2
    check("miss_c2_rv",    acs.acs_rvalid, 1);
    check("miss_c2_err",   acs.acs_error, 1);
    check("miss_c2_rdata", acs.acs_rdata, 0);
    check("miss_c2_cen",   s_cen, 0);
    tick();

    // ---- timeout on slot 2 (TIMEOUT=8) ----
    acs.acs_valid = 1'b1; acs.acs_addr = 32'hB000_0004;
    for (int c = 1; c <= 8; c++) begin
      tick();
      acs.acs_valid = 1'b0;
      check($sformatf("to_c%0d_cen", c), s_cen, 4'b0100);
      check($sformatf("to_c%0d_rv", c), acs.acs_rvalid, 0);
    end
    tick();                                         // cycle 9
    check("to_c9_cen",   s_cen, 0);
    check("to_c9_rv",    acs.acs_rvalid, 1);
    check("to_c9_err",   acs.acs_error, 1);
    check("to_c9_rdata", acs.acs_rdata, 0);
    tick();

    // ---- rvalid exactly at the timeout threshold wins ----
    acs.acs_valid = 1'b1; acs.acs_addr = 32'hB000_0008;
    for (int c = 1; c <= 7; c++) begin
      tick();
      acs.acs_valid = 1'b0;
    end
    tick();                                         // cycle 8
    s_rdata[95:64] = 32'h5A5A_0008; s_rvalid = 4'b0100;
    tick();                                         // cycle 9
    s_rvalid = '0;
    check("thr_rv",    acs.acs_rvalid, 1);
    check("thr_err",   acs.acs_error, 0);
    check("thr_rdata", acs.acs_rdata, 32'h5A5A_0008);
    tick();

    // ---- slave error, with a stray rvalid on an unselected slot ----
    acs.acs_valid = 1'b1; acs.acs_addr = 32'h8000_0020;
    tick();                                         // cycle 1
    acs.acs_valid = 1'b0;
    s_rvalid = 4'b0010; s_error = 4'b0010;
    tick();                                         // cycle 2
    check("serr_c2_cen", s_cen, 4'b0001);
    check("serr_c2_rv",  acs.acs_rvalid, 0);
    s_rdata[31:0] = 32'h0000_1234; s_rvalid = 4'b0001; s_error = 4'b0001;
    tick();                                         // cycle 3
    s_rvalid = '0; s_error = '0;
    check("serr_c3_rv",    acs.acs_rvalid, 1);
    check("serr_c3_err",   acs.acs_error, 1);
    check("serr_c3_rdata", acs.acs_rdata, 32'h0000_1234);
    tick();

    // ---- reset during BUSY ----
    acs.acs_valid = 1'b1; acs.acs_addr = 32'h8000_0000;
    tick();                                         // cycle 1, BUSY
    acs.acs_valid = 1'b0;
    check("arst_pre_cen", s_cen, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("arst_cen",   s_cen, 0);
    check("arst_rv",    acs.acs_rvalid, 0);
    check("arst_ready", acs.acs_ready, 1);
    check("arst_rdata", acs.acs_rdata, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("arst_norsp1", acs.acs_rvalid, 0);
    tick();
    check("arst_norsp2", acs.acs_rvalid, 0);
    acs.acs_valid = 1'b1; acs.acs_addr = 32'hA000_0040;
    tick();                                         // cycle 1
    acs.acs_valid = 1'b0;
    check("post_c1_cen", s_cen, 4'b0010);
    s_rdata[63:32] = 32'hCAFE_F00D; s_rvalid = 4'b0010;
    tick();                                         // cycle 2
    s_rvalid = '0;
    check("post_c2_rv",    acs.acs_rvalid, 1);
    check("post_c2_rdata", acs.acs_rdata, 32'hCAFE_F00D);
    check("post_c2_err",   acs.acs_error, 0);
    tick();

    // ---- RV64: upper word not a sign extension -> error ----
    acs64.acs_valid = 1'b1; acs64.acs_addr = 64'h0000_0001_8000_0000;
    tick();                                         // cycle 1
    acs64.acs_valid = 1'b0;
    check("rv64bad_c1_cen", s64_cen, 0);
    tick();                                         // cycle 2
    check("rv64bad_c2_rv",    acs64.acs_rvalid, 1);
    check("rv64bad_c2_err",   acs64.acs_error, 1);
    check("rv64bad_c2_rdata", acs64.acs_rdata, 0);
    check("rv64bad_c2_cen",   s64_cen, 0);
    tick();

    // ---- RV64: all-ones upper word decodes normally ----
    acs64.acs_valid = 1'b1; acs64.acs_addr = 64'hFFFF_FFFF_8000_0008;
    tick();                                         // cycle 1
    acs64.acs_valid = 1'b0;
    check("rv64ok_c1_cen", s64_cen, 4'b0001);
    s64_rdata[63:0] = 64'h0123_4567_89AB_CDEF; s64_rvalid = 4'b0001;
    tick();                                         // cycle 2
    s64_rvalid = '0;
    check("rv64ok_c2_rv",    acs64.acs_rvalid, 1);
    check("rv64ok_c2_err",   acs64.acs_error, 0);
    check("rv64ok_c2_rdata", acs64.acs_rdata, 64'h0123_4567_89AB_CDEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_xbar_fsm.md
Name: bus_xbar_fsm

Overview:
- Registered, parametrised successor to the single-cycle address-decode bus.
- Accepts one CPU data access at a time through a valid/ready request and rvalid response handshake.
- Decodes the address onto one of NSLV slave ports, holds the slave select until the slave responds, and returns rdata/error to the CPU.
- Adds multi-cycle slave support, a per-access timeout and decode-miss errors. Sits between the core LSU and memory/uart/timer/future peripherals.

Parameters:
- XLEN, 32, data/address width; 32 or 64.
- NSLV, 4, number of slave ports; 1..8.
- SEL_W, 5, number of address MSBs used for decode (bits XLEN32-1 down to 32-SEL_W of the low word).
- SLV_BASE, {5'b10110,5'b10100,5'b10000,5'b00000}, packed NSLV*SEL_W; slot k matches when addr[31:32-SEL_W]==SLV_BASE[k].
- SLV_EN, 4'b0111, per-slot enable; a disabled slot never matches.
- TIMEOUT, 255, maximum cycles to wait for slave rvalid; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acs_valid  in  1  CPU request valid.
- acs_ready  out  1  request accepted when valid&&ready.
- acs_wr  in  1  1=write.
- acs_bytes  in  XLEN/8  byte strobes.
- acs_addr  in  XLEN  address.
- acs_wdata  in  XLEN  write data.
- acs_rvalid  out  1  one-cycle response pulse.
- acs_rdata  out  XLEN  read data; valid with acs_rvalid.
- acs_error  out  1  error flag; valid with acs_rvalid.
- s_cen  out  NSLV  one-hot slave select.
- s_wr  out  1  registered acs_wr.
- s_strb  out  XLEN/8  registered strobes.
- s_addr  out  32-SEL_W  registered address low bits.
- s_wdata  out  XLEN  registered write data.
- s_rdata  in  NSLV*XLEN  slave read data, slot k at [k*XLEN +: XLEN].
- s_rvalid  in  NSLV  slave completion.
- s_error  in  NSLV  slave error, sampled with s_rvalid.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, s_cen=0, acs_rvalid=0, acs_error=0, acs_rdata=0, s_wr/s_strb/s_addr/s_wdata=0, timeout counter=0. acs_ready=1 while in IDLE.
- acs_ready is combinational: (state==IDLE). No request is accepted outside IDLE.
- IDLE, on acs_valid:
  - Latch wr/strb/addr/wdata into the s_* registers.
  - Hit on slot k (lowest k wins if several match) -> BUSY, s_cen[k]=1 from the next cycle.
  - No hit, or (XLEN==64 and addr[63:32] is neither 0 nor all-ones) -> ERR.
- BUSY:
  - s_cen stays one-hot and constant; counter increments each cycle.
  - If s_rvalid[k]: capture s_rdata slot k (0 for writes) and s_error[k], clear s_cen -> RESP.
  - s_rvalid on non-selected slots is ignored.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: clear s_cen, rdata=0, error=1 -> RESP.
- ERR: one cycle; rdata=0, error=1 -> RESP. No s_cen is asserted.
- RESP: acs_rvalid=1 for exactly one cycle with the registered rdata/error, then -> IDLE. acs_rvalid is low in every other state.
- Latency:
  - Request accepted in cycle 0; s_cen high from cycle 1.
  - Slave rvalid in cycle n>=1 gives acs_rvalid in cycle n+1.
  - Zero-wait slave (rvalid in cycle 1): acs_rvalid in cycle 2, next accept in cycle 3.
  - Decode error: acs_rvalid in cycle 2.
- acs_rdata/acs_error hold their last value outside RESP; only the rvalid cycle is meaningful.
- Counter clears on entry to BUSY. It saturates and never wraps: an 8-bit counter covers TIMEOUT=255; width is clog2(TIMEOUT+1).
- Reset mid-access: everything returns to reset values immediately, including s_cen. No response is produced for the aborted access.
- A slave rvalid arriving in the same cycle as the timeout threshold wins: normal response, no timeout error.

Test Plan:
- Read slot 0 (addr 0x8000_0010), slave returns rdata 0xDEAD_BEEF with rvalid in cycle 1 -> s_cen=4'b0001 in cycle 1, acs_rvalid in cycle 2 with rdata 0xDEAD_BEEF, error=0, acs_ready=1 again in cycle 3.
- Write slot 1 (addr 0xA000_0000, wdata 0x41, bytes 4'b0001), rvalid after 5 wait cycles -> s_cen=4'b0010 held for cycles 1..6, s_wdata=0x41, s_strb=1, acs_rvalid in cycle 7 with error=0.
- Decode miss (addr 0x1000_0000; slot 3 disabled) -> s_cen stays 0, acs_rvalid in cycle 2 with error=1, rdata=0.
- TIMEOUT=8, slave never responds -> s_cen high for cycles 1..8, low from cycle 9, acs_rvalid with error=1 in cycle 9.
- Slave rvalid with s_error=1 -> acs_error=1 in the response cycle; s_rvalid on an unselected slot during BUSY is ignored.
- rst_n low during BUSY -> s_cen, acs_rvalid and state clear asynchronously; the next access after reset completes normally.
- RV64 build, addr 0x0000_0001_8000_0000 -> response with error=1, no s_cen.
